unidade_busca: RTL and testbench
================================

Name: unidade_busca

Overview:
Instruction fetch stage that sits directly upstream of the control unit.
- Holds the program counter and issues word fetches to instruction memory over a req/ready handshake.
- Buffers returned instructions in an IF/ID output register plus a one-entry skid buffer.
- Presents the 6-bit opcode to the control unit.
- Honours downstream stalls and branch/jump redirects (flush).

Parameters:
- DATA_W, 32, instruction and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, PC increment per fetched instruction.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- redirect_valid  in  1  one-cycle pulse from a later stage: branch taken or jump.
- redirect_pc  in  DATA_W  redirect target; bits [1:0] forced to 0 internally.
- imem_req  out  1  fetch request (registered).
- imem_addr  out  DATA_W  fetch address (registered); stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  memory returns imem_data this cycle; ignored when imem_req=0.
- imem_data  in  DATA_W  fetched instruction word.
- id_ready  in  1  downstream accepts the IF/ID contents this cycle.
- if_valid  out  1  IF/ID holds a valid instruction.
- if_instr  out  DATA_W  instruction word.
- if_pc  out  DATA_W  address of if_instr.
- if_pc4  out  DATA_W  if_pc + PC_STEP (combinational).
- if_opcode  out  6  if_valid ? if_instr[31:26] : 6'b111111 (combinational; 111111 decodes to all controls deasserted).

Behaviour:
- Reset (wins over all inputs):
  - pc=RESET_PC, imem_req=0, imem_addr=0.
  - if_valid=0, if_instr=0, if_pc=0.
  - skid empty, discard=0, state=IDLE.
- Handshake: once imem_req=1, imem_addr must not change until a cycle where imem_ready=1 (response in that cycle). At most one request is outstanding.
- States:
  - IDLE: one cycle after reset; next cycle imem_req=1, imem_addr=pc → FETCH.
  - FETCH: request outstanding.
  - WAIT: no request, because the skid buffer is full.
- FETCH, response with discard=0:
  - If IF/ID is empty or consumed this cycle (id_ready=1): load if_instr=imem_data, if_pc=imem_addr, if_valid=1.
  - Otherwise: load the skid buffer.
  - In both cases pc=imem_addr+PC_STEP.
  - Next request: if the skid buffer is now empty, issue next cycle at the new pc (zero-wait memory gives 1 instruction/cycle). Otherwise drop imem_req → WAIT.
- FETCH, response with discard=1: drop the data, clear discard, issue the next request at pc (the redirect target).
- WAIT: when id_ready=1, skid → IF/ID; next cycle reissue at pc → FETCH.
- Consume without refill: id_ready=1 with no new data → if_valid=0 next cycle.
- Redirect (redirect_valid=1), priority over id_ready and responses:
  - if_valid=0, skid emptied, pc=redirect_pc&~3.
  - The current IF/ID instruction counts as flushed even if id_ready=1.
  - Request outstanding and imem_ready=0: set discard=1, keep imem_addr until the response arrives.
  - imem_ready=1 in the same cycle: drop the data, no discard needed; next request at the redirect target.
  - In IDLE or WAIT: next request goes to the redirect target.
- Redirect while discard=1: update pc only; discard stays 1.
- PC arithmetic: modulo 2^DATA_W; 32'hFFFF_FFFC + 4 = 0.
- Ordering: no instruction is lost or duplicated across stalls; program order is preserved.

Test Plan:
- Reset, imem_ready tied 1, memory[i]=i<<26, id_ready=1:
  - imem_addr sequence 0,4,8,…; one request per cycle after IDLE.
  - if_pc=0,4,8 on consecutive cycles; if_opcode=0,1,2.
- Stall: id_ready=0 for 5 cycles at if_pc=8:
  - if_pc stays 8; skid captures 12; imem_req drops.
  - On release: 8 then 12 on consecutive cycles, then reissue at 16; no gaps in pc sequence.
- Memory latency 3 cycles, redirect_valid with redirect_pc=32'h40 one cycle after a request to 0x10:
  - imem_addr held at 0x10 until its response; that response is discarded.
  - Next request to 0x40; next valid instruction has if_pc=0x40.
- Redirect and id_ready in the same cycle while if_valid=1:
  - if_valid=0 next cycle; if_opcode=6'b111111; first new if_pc = redirect target.
- Wrap: RESET_PC=32'hFFFF_FFF8, zero-wait memory → if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- reset asserted mid-fetch with latency-2 memory:
  - Next cycle imem_req=0, if_valid=0; a late imem_ready is ignored.
  - After reset release, first request to RESET_PC.

Source files
------------

// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch stage feeding the control unit.
// Keeps the PC, issues single-outstanding word fetches over req/ready,
// buffers responses in an IF/ID register backed by a one-entry skid buffer,
// and handles downstream stalls and branch/jump redirects.
module unidade_busca #(
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [DATA_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_pc4,
  output logic [5:0]        if_opcode
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  // Registered state
  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_pc;
  logic              r_req;
  logic [DATA_W-1:0] r_addr;
  logic              r_valid;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_ifpc;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_instr;
  logic [DATA_W-1:0] r_skid_pc;
  logic              r_discard;

  // Next-state values
  logic [1:0]        w_state;
  logic [DATA_W-1:0] w_pc;
  logic              w_req;
  logic [DATA_W-1:0] w_addr;
  logic              w_valid;
  logic [DATA_W-1:0] w_instr;
  logic [DATA_W-1:0] w_ifpc;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_instr;
  logic [DATA_W-1:0] w_skid_pc;
  logic              w_discard;

  logic [DATA_W-1:0] w_step;
  logic [DATA_W-1:0] w_redir_pc;
  logic [DATA_W-1:0] w_addr_next;

  assign w_step      = DATA_W'(PC_STEP);
  assign w_redir_pc  = redirect_pc & ~DATA_W'(3);
  assign w_addr_next = r_addr + w_step;

  // Next-state logic: redirect has priority over responses and consumption
  always_comb begin
    w_state      = r_state;
    w_pc         = r_pc;
    w_req        = r_req;
    w_addr       = r_addr;
    w_valid      = r_valid;
    w_instr      = r_instr;
    w_ifpc       = r_ifpc;
    w_skid_valid = r_skid_valid;
    w_skid_instr = r_skid_instr;
    w_skid_pc    = r_skid_pc;
    w_discard    = r_discard;

    if (id_ready) begin
      w_valid = 1'b0;
    end

    if (redirect_valid) begin
      w_valid      = 1'b0;
      w_skid_valid = 1'b0;
      w_pc         = w_redir_pc;
      if (r_state == S_FETCH) begin
        if (imem_ready) begin
          // Response lands now: drop it and go straight to the target.
          w_addr    = w_redir_pc;
          w_req     = 1'b1;
          w_discard = 1'b0;
        end else begin
          // Address must stay put until the stale response arrives.
          w_discard = 1'b1;
        end
      end else begin
        w_req   = 1'b1;
        w_addr  = w_redir_pc;
        w_state = S_FETCH;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          w_req   = 1'b1;
          w_addr  = r_pc;
          w_state = S_FETCH;
        end
        S_FETCH: begin
          if (imem_ready) begin
            if (r_discard) begin
              w_discard = 1'b0;
              w_addr    = r_pc;
            end else begin
              if (!r_valid || id_ready) begin
                w_valid = 1'b1;
                w_instr = imem_data;
                w_ifpc  = r_addr;
              end else begin
                w_skid_valid = 1'b1;
                w_skid_instr = imem_data;
                w_skid_pc    = r_addr;
              end
              w_pc = w_addr_next;
              if (w_skid_valid) begin
                w_req   = 1'b0;
                w_state = S_WAIT;
              end else begin
                w_addr = w_addr_next;
              end
            end
          end
        end
        S_WAIT: begin
          if (id_ready) begin
            w_valid      = 1'b1;
            w_instr      = r_skid_instr;
            w_ifpc       = r_skid_pc;
            w_skid_valid = 1'b0;
            w_req        = 1'b1;
            w_addr       = r_pc;
            w_state      = S_FETCH;
          end
        end
        default: begin
          w_state = S_IDLE;
          w_req   = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_valid      <= 1'b0;
      r_instr      <= '0;
      r_ifpc       <= '0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_discard    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_pc         <= w_pc;
      r_req        <= w_req;
      r_addr       <= w_addr;
      r_valid      <= w_valid;
      r_instr      <= w_instr;
      r_ifpc       <= w_ifpc;
      r_skid_valid <= w_skid_valid;
      r_skid_instr <= w_skid_instr;
      r_skid_pc    <= w_skid_pc;
      r_discard    <= w_discard;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign if_valid  = r_valid;
  assign if_instr  = r_instr;
  assign if_pc     = r_ifpc;
  assign if_pc4    = r_ifpc + w_step;
  assign if_opcode = r_valid ? r_instr[DATA_W-1 -: 6] : 6'b111111;

endmodule

// File: tb/tb_unidade_busca.sv
// Directed testbench for unidade_busca: streaming, stall/skid, redirect with
// slow memory, redirect racing a consume, PC wrap and reset mid-fetch.
module tb_unidade_busca;

  logic        clock;
  int          checks;
  int          failures;

  // DUT A: RESET_PC = 0, configurable-latency memory
  logic        rst_a;
  logic        redir_v;
  logic [31:0] redir_pc;
  logic        a_req;
  logic [31:0] a_addr;
  logic        a_ready;
  logic [31:0] a_data;
  logic        id_rdy;
  logic        a_valid;
  logic [31:0] a_instr;
  logic [31:0] a_pc;
  logic [31:0] a_pc4;
  logic [5:0]  a_op;

  // DUT B: RESET_PC near the top of the address space, zero-wait memory
  logic        rst_b;
  logic        b_req;
  logic [31:0] b_addr;
  logic [31:0] b_data;
  logic        b_valid;
  logic [31:0] b_instr;
  logic [31:0] b_pc;
  logic [31:0] b_pc4;
  logic [5:0]  b_op;

  int unsigned lat;
  int unsigned cnt;
  logic        force_rdy;

  unidade_busca #(.DATA_W(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut_a (
    .clock(clock), .reset(rst_a),
    .redirect_valid(redir_v), .redirect_pc(redir_pc),
    .imem_req(a_req), .imem_addr(a_addr), .imem_ready(a_ready), .imem_data(a_data),
    .id_ready(id_rdy), .if_valid(a_valid), .if_instr(a_instr), .if_pc(a_pc),
    .if_pc4(a_pc4), .if_opcode(a_op)
  );

  unidade_busca #(.DATA_W(32), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_b (
    .clock(clock), .reset(rst_b),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ready(1'b1), .imem_data(b_data),
    .id_ready(1'b1), .if_valid(b_valid), .if_instr(b_instr), .if_pc(b_pc),
    .if_pc4(b_pc4), .if_opcode(b_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: word i holds i<<26, i.e. addr<<24; ready after lat wait cycles
  assign a_data  = a_addr << 24;
  assign b_data  = b_addr << 24;
  assign a_ready = force_rdy | (a_req && (cnt >= lat));

  always_ff @(posedge clock) begin
    if (!a_req || a_ready) cnt <= 0;
    else                   cnt <= cnt + 1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    checks    = 0;
    failures  = 0;
    rst_a     = 1'b1;
    rst_b     = 1'b1;
    redir_v   = 1'b0;
    redir_pc  = '0;
    id_rdy    = 1'b1;
    lat       = 0;
    force_rdy = 1'b0;

    // Reset state
    step();
    step();
    check("rst_req",   {31'd0, a_req},   32'd0);
    check("rst_addr",  a_addr,           32'd0);
    check("rst_valid", {31'd0, a_valid}, 32'd0);
    check("rst_instr", a_instr,          32'd0);
    check("rst_pc",    a_pc,             32'd0);
    check("rst_op",    {26'd0, a_op},    32'h3F);
    rst_a = 1'b0;

    // Zero-wait streaming
    step();
    check("idle_req",  {31'd0, a_req},   32'd1);
    check("idle_addr", a_addr,           32'd0);
    check("idle_valid",{31'd0, a_valid}, 32'd0);
    step();
    check("s0_pc",   a_pc,          32'd0);
    check("s0_op",   {26'd0, a_op}, 32'd0);
    check("s0_addr", a_addr,        32'd4);
    step();
    check("s1_pc",   a_pc,          32'd4);
    check("s1_op",   {26'd0, a_op}, 32'd1);
    check("s1_addr", a_addr,        32'd8);
    step();
    check("s2_pc",   a_pc,          32'd8);
    check("s2_op",   {26'd0, a_op}, 32'd2);
    check("s2_pc4",  a_pc4,         32'd12);

    // Stall five cycles at if_pc=8; 12 goes into the skid, request drops
    id_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_pc",    a_pc,            32'd8);
      check("stall_req",   {31'd0, a_req},  32'd0);
      check("stall_valid", {31'd0, a_valid},32'd1);
    end
    id_rdy = 1'b1;
    step();
    check("rel_pc",   a_pc,           32'd12);
    check("rel_req",  {31'd0, a_req}, 32'd1);
    check("rel_addr", a_addr,         32'd16);
    step();
    check("rel2_pc",    a_pc,          32'd16);
    check("rel2_instr", a_instr,       32'h1000_0000);
    check("rel2_op",    {26'd0, a_op}, 32'd4);

    // Latency-3 memory, redirect one cycle after the request to 0x10
    rst_a = 1'b1;
    lat   = 3;
    step();
    step();
    rst_a = 1'b0;
    n = 0;
    while (!(a_req && a_addr == 32'h10) && n < 60) begin
      step();
      n++;
    end
    check("lat_reach10", (n < 60) ? 32'd1 : 32'd0, 32'd1);
    step();
    redir_v  = 1'b1;
    redir_pc = 32'h0000_0042;
    step();
    redir_v  = 1'b0;
    check("rd_hold_addr", a_addr,           32'h10);
    check("rd_hold_req",  {31'd0, a_req},   32'd1);
    check("rd_valid",     {31'd0, a_valid}, 32'd0);
    check("rd_op",        {26'd0, a_op},    32'h3F);
    step();
    check("rd_hold2_addr", a_addr, 32'h10);
    step();
    check("rd_new_addr", a_addr,           32'h40);
    check("rd_new_req",  {31'd0, a_req},   32'd1);
    check("rd_discard",  {31'd0, a_valid}, 32'd0);
    n = 0;
    while (!a_valid && n < 10) begin
      step();
      n++;
    end
    check("rd_first_pc",    a_pc,    32'h40);
    check("rd_first_instr", a_instr, 32'h4000_0000);

    // Redirect and consume in the same cycle while IF/ID is valid
    lat = 0;
    step();
    check("rc_pc",    a_pc,             32'h44);
    check("rc_valid", {31'd0, a_valid}, 32'd1);
    redir_v  = 1'b1;
    redir_pc = 32'h0000_0100;
    step();
    redir_v  = 1'b0;
    check("rc_flush_valid", {31'd0, a_valid}, 32'd0);
    check("rc_flush_op",    {26'd0, a_op},    32'h3F);
    check("rc_addr",        a_addr,           32'h100);
    step();
    check("rc_new_pc",  a_pc,  32'h100);
    check("rc_new_pc4", a_pc4, 32'h104);

    // Reset mid-fetch with latency-2 memory; a late ready must be ignored
    lat   = 2;
    rst_a = 1'b1;
    step();
    check("mr_req",   {31'd0, a_req},   32'd0);
    check("mr_valid", {31'd0, a_valid}, 32'd0);
    check("mr_addr",  a_addr,           32'd0);
    force_rdy = 1'b1;
    step();
    rst_a = 1'b0;
    step();
    force_rdy = 1'b0;
    check("mr_late_valid", {31'd0, a_valid}, 32'd0);
    check("mr_first_req",  {31'd0, a_req},   32'd1);
    check("mr_first_addr", a_addr,           32'd0);
    n = 0;
    while (!a_valid && n < 10) begin
      step();
      n++;
    end
    check("mr_first_pc", a_pc, 32'd0);

    // PC wrap on DUT B
    rst_b = 1'b0;
    step();
    check("wr_addr", b_addr,         32'hFFFF_FFF8);
    check("wr_req",  {31'd0, b_req}, 32'd1);
    step();
    check("wr_pc0", b_pc, 32'hFFFF_FFF8);
    step();
    check("wr_pc1",  b_pc,  32'hFFFF_FFFC);
    check("wr_pc4",  b_pc4, 32'h0000_0000);
    step();
    check("wr_pc2",   b_pc,             32'h0000_0000);
    check("wr_valid", {31'd0, b_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
